// File: rtl/minilab_pkg.sv
// -----------------------------------------------------------------------------
// minilab_pkg
// Shared defaults and types for the systolic MAC feeder.
//   DEF_DATA_WIDTH : default FIFO data / MAC operand width
//   DEF_ROWS       : default number of A-row FIFOs and MACs
//   DEF_DEPTH      : default elements per A row and in the B vector
//   feeder_state_t : feeder sequencing FSM states
// -----------------------------------------------------------------------------
package minilab_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROWS       = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int STALL_CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;

    // Number of global steps in one skewed matrix-vector pass.
    function automatic int step_count(input int rows, input int depth);
        return rows + depth - 1;
    endfunction

endpackage

// File: rtl/b_skew_line.sv
// -----------------------------------------------------------------------------
// b_skew_line
// Skew delay line for the B vector. Tap 0 is the B element just read from the
// FIFO; tap k is the element read k firing steps earlier, so MAC row k sees the
// B element that pairs with its own (k-step delayed) A stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   advance    : shift one position (cycle after a firing step)
//   din        : current B element (zero when B was not popped)
//   taps       : ROWS taps, taps[k] = B element delayed by k steps
// -----------------------------------------------------------------------------
module b_skew_line
    import minilab_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             advance,
    input  logic [DATA_WIDTH-1:0]            din,
    output logic [ROWS-1:0][DATA_WIDTH-1:0]  taps
);

    // Tap 0 is combinational, so only ROWS-1 registered stages are needed.
    logic [ROWS-2:0][DATA_WIDTH-1:0] stage;

    // NOTE: this is a handful of plain flops, not a RAM, so it is reset;
    // a stale element must never leak into the next operation after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else if (advance) begin
            stage[0] <= din;
            for (int k = 1; k < ROWS - 1; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    always_comb begin
        taps[0] = din;
        for (int k = 1; k < ROWS; k++) begin
            taps[k] = stage[k-1];
        end
    end

endmodule

// File: rtl/mac_feeder.sv
// -----------------------------------------------------------------------------
// mac_feeder
// Streams one matrix (ROWS x DEPTH, one FIFO per row) and one vector (DEPTH
// elements, one FIFO) into ROWS MACs with a diagonal skew: row i consumes its
// element k at global step i+k together with B element k.
// Optional feature macro: FEEDER_STALL_CNT_EN (enables the stall counter;
// otherwise stall_cnt is tied to zero).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle request, honoured only when idle
//   rdempty_a, q_a      : per-row A FIFO empty flags and read data (1-cycle)
//   rdempty_b, q_b      : B FIFO empty flag and read data (1-cycle)
//   rdreq_a, rdreq_b    : FIFO read requests
//   mac_clr             : one-cycle accumulator clear
//   mac_en, mac_a, mac_b: per-MAC accumulate enable and operands
//   busy, done          : operation in progress / completion pulse
//   stall_cnt           : STREAM cycles lost to empty FIFOs
// -----------------------------------------------------------------------------
module mac_feeder
    import minilab_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ROWS-1:0]                  rdempty_a,
    input  logic [ROWS-1:0][DATA_WIDTH-1:0]  q_a,
    input  logic                             rdempty_b,
    input  logic [DATA_WIDTH-1:0]            q_b,
    output logic [ROWS-1:0]                  rdreq_a,
    output logic                             rdreq_b,
    output logic                             mac_clr,
    output logic [ROWS-1:0]                  mac_en,
    output logic [ROWS-1:0][DATA_WIDTH-1:0]  mac_a,
    output logic [ROWS-1:0][DATA_WIDTH-1:0]  mac_b,
    output logic                             busy,
    output logic                             done,
    output logic [STALL_CNT_W-1:0]           stall_cnt
);

    localparam int STEPS = step_count(ROWS, DEPTH);
    localparam int SW    = $clog2(STEPS + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    feeder_state_t   state;
    logic [SW-1:0]   step;
    logic            b_popped;   // B was read in the previous cycle
    logic [ROWS-1:0] row_active;
    logic            b_active;
    logic            blocked;
    logic            fire;
    int              step_i;
    logic [ROWS-1:0][DATA_WIDTH-1:0] b_taps;
    logic [DATA_WIDTH-1:0]           b_din;

    assign step_i = int'(step);

    // A step fires only when every FIFO it needs has data, so a stall never
    // reads a subset of rows and the skew between rows is preserved.
    // NOTE: every signal gets a value on every path through this block, so
    // no latches are inferred.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            row_active[i] = (step_i >= i) && (step_i - i < DEPTH);
        end
        b_active = (step_i < DEPTH);
        blocked  = (|(row_active & rdempty_a)) || (b_active && rdempty_b);
        fire     = (state == ST_STREAM) && !blocked;
        rdreq_a  = fire ? row_active : '0;
        rdreq_b  = fire && b_active;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            step     <= '0;
            b_popped <= 1'b0;
            mac_en   <= '0;
            mac_clr  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // FIFO data lands one cycle after the read, so the enable is
            // simply the read request delayed by one cycle.
            mac_en   <= rdreq_a;
            b_popped <= rdreq_b;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CLEAR;
                        mac_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state   <= ST_STREAM;
                    mac_clr <= 1'b0;
                    step    <= '0;
                end
                ST_STREAM: begin
                    if (fire) begin
                        if (step == LAST_STEP) begin
                            state <= ST_DRAIN;
                            step  <= '0;
                        end else begin
                            step <= step + SW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    mac_clr <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Zero is shifted in once B is exhausted; those taps are never enabled.
    assign b_din = b_popped ? q_b : '0;

    b_skew_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (ROWS)
    ) u_b_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (|mac_en),
        .din     (b_din),
        .taps    (b_taps)
    );

    // Operands are gated by their enable so idle lanes (and reset) read zero.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            mac_a[i] = mac_en[i] ? q_a[i]    : '0;
            mac_b[i] = mac_en[i] ? b_taps[i] : '0;
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            stall_cnt <= '0;
        end else if ((state == ST_STREAM) && !fire && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_feeder
// Self-checking bench for mac_feeder: a table of per-cycle expectations for the
// nominal pass, hand-written stall/reset/restart sequences, and randomized
// FIFO-empty stimulus checked against per-row operand sequences.
// -----------------------------------------------------------------------------
module tb_mac_feeder;

    localparam int DW    = 8;
    localparam int ROWS  = 8;
    localparam int DEPTH = 8;
    localparam int NV    = 20;
    localparam int MAXC  = 300;
    localparam int FD    = 256;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic [ROWS-1:0]            rdempty_a;
    logic [ROWS-1:0][DW-1:0]    q_a;
    logic                       rdempty_b;
    logic [DW-1:0]              q_b;
    logic [ROWS-1:0]            rdreq_a;
    logic                       rdreq_b;
    logic                       mac_clr;
    logic [ROWS-1:0]            mac_en;
    logic [ROWS-1:0][DW-1:0]    mac_a;
    logic [ROWS-1:0][DW-1:0]    mac_b;
    logic                       busy;
    logic                       done;
    logic [15:0]                stall_cnt;

    mac_feeder #(
        .DATA_WIDTH (DW),
        .ROWS       (ROWS),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rdempty_a (rdempty_a),
        .q_a       (q_a),
        .rdempty_b (rdempty_b),
        .q_b       (q_b),
        .rdreq_a   (rdreq_a),
        .rdreq_b   (rdreq_b),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO models (data valid the cycle after rdreq) --------
    logic [DW-1:0] fifo_a [ROWS][FD];
    logic [DW-1:0] fifo_b [FD];
    int            wr_a [ROWS];
    int            wr_b;
    int            rd_a [ROWS];
    int            rd_b;
    int            bad_reads;
    logic          flush;

    always @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < ROWS; i++) rd_a[i] = wr_a[i];
            rd_b = wr_b;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (rdreq_a[i]) begin
                    if (rdempty_a[i]) bad_reads++;
                    if (rd_a[i] != wr_a[i]) begin
                        q_a[i] <= fifo_a[i][rd_a[i] % FD];
                        rd_a[i]++;
                    end
                end
            end
            if (rdreq_b) begin
                if (rdempty_b) bad_reads++;
                if (rd_b != wr_b) begin
                    q_b <= fifo_b[rd_b % FD];
                    rd_b++;
                end
            end
        end
    end

    // ---------------- stimulus state -----------------------------------------
    int hold_mode;    // 0 none, 1 B empty early, 2 row 7 empty mid-run, 3 random
    int restart_at;
    int cyc;

    logic [DW-1:0] exp_a [ROWS][DEPTH];
    logic [DW-1:0] exp_b [DEPTH];
    logic [DW-1:0] got_a [ROWS][DEPTH];
    logic [DW-1:0] got_b [ROWS][DEPTH];
    int            got_n [ROWS];
    int            n_done;
    logic [ROWS-1:0] prev_rdreq;

    typedef struct {
        logic                    start;
        logic [ROWS-1:0]         rdreq_a;
        logic                    rdreq_b;
        logic                    mac_clr;
        logic [ROWS-1:0]         mac_en;
        logic [ROWS-1:0][DW-1:0] mac_a;
        logic [ROWS-1:0][DW-1:0] mac_b;
        logic                    busy;
        logic                    done;
    } vec_t;
    vec_t vec [NV];

    task automatic update_empty();
        for (int i = 0; i < ROWS; i++) rdempty_a[i] = (rd_a[i] == wr_a[i]);
        rdempty_b = (rd_b == wr_b);
        case (hold_mode)
            1: if (cyc >= 2 && cyc <= 6) rdempty_b = 1'b1;
            2: if (cyc >= 9 && cyc <= 11) rdempty_a[7] = 1'b1;
            3: if (cyc > 0) begin
                for (int i = 0; i < ROWS; i++)
                    if ($urandom_range(0, 5) == 0) rdempty_a[i] = 1'b1;
                if ($urandom_range(0, 4) == 0) rdempty_b = 1'b1;
            end
            default: ;
        endcase
    endtask

    // kind 0: A row i = i+1, B = 1..DEPTH; kind 1: all 8'hFF; kind 2: random
    task automatic load(input int kind);
        logic [DW-1:0] v;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                v = (kind == 0) ? DW'(i + 1) : (kind == 1) ? 8'hFF : DW'($urandom);
                exp_a[i][k] = v;
                fifo_a[i][wr_a[i] % FD] = v;
                wr_a[i]++;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            v = (kind == 0) ? DW'(k + 1) : (kind == 1) ? 8'hFF : DW'($urandom);
            exp_b[k] = v;
            fifo_b[wr_b % FD] = v;
            wr_b++;
        end
        update_empty();
        #1;
    endtask

    task automatic advance();
        @(negedge clk);
        cyc++;
        start = (cyc == restart_at);
        update_empty();
        #1;
    endtask

    task automatic clear_got();
        for (int i = 0; i < ROWS; i++) got_n[i] = 0;
        n_done     = 0;
        prev_rdreq = '0;
    endtask

    // Per-cycle rules that hold in every scenario, plus operand capture.
    task automatic sample();
        check($sformatf("mac_en_after_rdreq_c%0d", cyc), mac_en, prev_rdreq);
        if (!busy || mac_clr || done)
            check($sformatf("no_rdreq_outside_stream_c%0d", cyc), {rdreq_a, rdreq_b}, '0);
        for (int i = 0; i < ROWS; i++) begin
            if (mac_en[i]) begin
                if (got_n[i] < DEPTH) begin
                    got_a[i][got_n[i]] = mac_a[i];
                    got_b[i][got_n[i]] = mac_b[i];
                end
                got_n[i]++;
            end
        end
        if (done) n_done++;
        prev_rdreq = rdreq_a;
    endtask

    // Each row must see exactly A[i][0..DEPTH-1] paired with B[0..DEPTH-1].
    task automatic score(input string tag);
        for (int i = 0; i < ROWS; i++) begin
            check($sformatf("%s_row%0d_pulses", tag, i), got_n[i], DEPTH);
            for (int k = 0; k < DEPTH; k++) begin
                if (k < got_n[i]) begin
                    check($sformatf("%s_row%0d_a%0d", tag, i, k), got_a[i][k], exp_a[i][k]);
                    check($sformatf("%s_row%0d_b%0d", tag, i, k), got_b[i][k], exp_b[k]);
                end
            end
        end
        check($sformatf("%s_read_while_empty", tag), bad_reads, 0);
    endtask

    task automatic run_op(input int mode, input int rs_at, output int done_cyc, output int first_en0);
        clear_got();
        hold_mode  = mode;
        restart_at = rs_at;
        done_cyc   = -1;
        first_en0  = -1;
        cyc        = 0;
        start      = 1'b1;
        update_empty();
        #1;
        for (int c = 0; c < MAXC; c++) begin
            sample();
            if (cyc == 1) check("mac_clr_cycle1", mac_clr, 1'b1);
            if (mac_en[0] && first_en0 < 0) first_en0 = cyc;
            if (mode == 1 && cyc >= 2 && cyc <= 6)
                check($sformatf("b_empty_no_rdreq_c%0d", cyc), {rdreq_a, rdreq_b}, '0);
            if (mode == 2 && cyc >= 9 && cyc <= 11)
                check($sformatf("a7_empty_no_rdreq_c%0d", cyc), {rdreq_a, rdreq_b}, '0);
            if (mode == 2 && cyc == 12)
                check("a7_resume_rdreq", rdreq_a[7], 1'b1);
            if (done && done_cyc < 0) done_cyc = cyc;
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            advance();
        end
        if (done_cyc < 0) begin
            check("done_timeout", 1'b0, 1'b1);
        end else begin
            check("busy_low_after_done", busy, 1'b0);
        end
        repeat (3) begin
            advance();
            sample();
        end
        check("single_done_pulse", n_done, 1);
        hold_mode  = 0;
        restart_at = -1;
    endtask

    logic [15:0] exp_stall;
    int dc, fe;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        hold_mode  = 0;
        restart_at = -1;
        flush      = 1'b0;
        cyc        = 0;
        bad_reads  = 0;

        // Nominal-pass expectations derived from the step/skew rules.
        for (int c = 0; c < NV; c++) begin
            vec[c].start   = (c == 0);
            vec[c].rdreq_b = (c >= 2 && c <= 9);
            vec[c].mac_clr = (c == 1);
            vec[c].busy    = (c >= 1 && c <= 18);
            vec[c].done    = (c == 18);
            for (int i = 0; i < ROWS; i++) begin
                vec[c].rdreq_a[i] = (c >= 2 + i && c <= 9 + i);
                vec[c].mac_en[i]  = (c >= 3 + i && c <= 10 + i);
                vec[c].mac_a[i]   = vec[c].mac_en[i] ? DW'(i + 1) : '0;
                vec[c].mac_b[i]   = vec[c].mac_en[i] ? DW'(c - 2 - i) : '0;
            end
        end

        update_empty();
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mac_clr", mac_clr, 1'b0);
        check("rst_mac_en", mac_en, '0);
        check("rst_rdreq", {rdreq_a, rdreq_b}, '0);
        check("rst_stall_cnt", stall_cnt, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- nominal pass, table-driven ----
        load(0);
        clear_got();
        cyc = 0;
        for (int c = 0; c < NV; c++) begin
            if (c > 0) begin
                @(negedge clk);
                cyc = c;
            end
            start = vec[c].start;
            update_empty();
            #1;
            check($sformatf("tab_rdreq_a_c%0d", c), rdreq_a, vec[c].rdreq_a);
            check($sformatf("tab_rdreq_b_c%0d", c), rdreq_b, vec[c].rdreq_b);
            check($sformatf("tab_mac_clr_c%0d", c), mac_clr, vec[c].mac_clr);
            check($sformatf("tab_mac_en_c%0d", c), mac_en, vec[c].mac_en);
            check($sformatf("tab_busy_c%0d", c), busy, vec[c].busy);
            check($sformatf("tab_done_c%0d", c), done, vec[c].done);
            for (int i = 0; i < ROWS; i++) begin
                if (vec[c].mac_en[i]) begin
                    check($sformatf("tab_mac_a_c%0d_r%0d", c, i), mac_a[i], vec[c].mac_a[i]);
                    check($sformatf("tab_mac_b_c%0d_r%0d", c, i), mac_b[i], vec[c].mac_b[i]);
                end
            end
            sample();
        end
        score("nominal");
        check("nominal_stall_cnt", stall_cnt, 16'h0);

        // ---- B FIFO empty for the first 5 STREAM cycles ----
        load(0);
        run_op(1, -1, dc, fe);
        score("b_late");
        check("b_late_first_en0", fe, 8);
        check("b_late_done_cyc", dc, 23);
`ifdef FEEDER_STALL_CNT_EN
        exp_stall = 16'd5;
`else
        exp_stall = 16'd0;
`endif
        check("b_late_stall_cnt", stall_cnt, exp_stall);

        // ---- row 7 empty for 3 cycles mid-run ----
        load(0);
        run_op(2, -1, dc, fe);
        score("a7_hold");
        check("a7_hold_done_cyc", dc, 21);

        // ---- start pulsed again while busy ----
        load(0);
        run_op(0, 6, dc, fe);
        score("restart");
        check("restart_done_cyc", dc, 18);

        // ---- all-ones operands ----
        load(1);
        run_op(0, -1, dc, fe);
        score("all_ff");

        // ---- reset mid-operation, then a fresh run ----
        load(0);
        cyc        = 0;
        restart_at = -1;
        start      = 1'b1;
        update_empty();
        #1;
        while (cyc < 8) advance();
        check("pre_reset_active", mac_en != '0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdreq", {rdreq_a, rdreq_b}, '0);
        check("mid_rst_mac_en", mac_en, '0);
        check("mid_rst_mac_a", mac_a, '0);
        check("mid_rst_mac_b", mac_b, '0);
        check("mid_rst_flags", {mac_clr, busy, done}, 3'b000);
        check("mid_rst_stall_cnt", stall_cnt, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load(0);
        run_op(0, -1, dc, fe);
        score("after_reset");
        check("after_reset_done_cyc", dc, 18);

        // ---- randomized empties and data ----
        for (int r = 0; r < 4; r++) begin
            load(2);
            run_op(3, -1, dc, fe);
            score($sformatf("rand%0d", r));
            // Every STREAM cycle beyond the nominal STEPS is a stall.
`ifdef FEEDER_STALL_CNT_EN
            exp_stall = 16'(dc - 18);
`else
            exp_stall = 16'd0;
`endif
            check($sformatf("rand%0d_stall_cnt", r), stall_cnt, exp_stall);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO data and MAC operands.
REQ-002 Parameter ROWS, default 8, number of matrix A row FIFOs and MACs.
REQ-003 Parameter DEPTH, default 8, number of elements per A row and in the B vector.
REQ-004 clk  input  1  single clock for all logic and both FIFO read ports.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle request to run one matrix-vector product.
REQ-007 rdempty_a  input  ROWS  per-row A FIFO empty flags.
REQ-008 q_a  input  ROWS x DATA_WIDTH  per-row A FIFO read data, valid the cycle after rdreq.
REQ-009 rdempty_b / q_b  input  1 / DATA_WIDTH  B FIFO empty flag and read data, same latency.
REQ-010 rdreq_a / rdreq_b  output  ROWS / 1  FIFO read requests.
REQ-011 mac_clr  output  1  one-cycle accumulator clear to all MACs.
REQ-012 mac_en  output  ROWS  per-MAC accumulate enable.
REQ-013 mac_a / mac_b  output  ROWS x DATA_WIDTH each  per-MAC operands.
REQ-014 busy / done  output  1 / 1  operation in progress; one-cycle completion pulse.
REQ-015 stall_cnt  output  16  stalled-cycle count (see Configuration).

Function
REQ-016 FSM states IDLE, CLEAR, STREAM, DRAIN, DONE; IDLE->CLEAR on start, CLEAR->STREAM after one cycle, STREAM->DRAIN in the cycle after the final step fires, DRAIN->DONE->IDLE one cycle each.
REQ-017 start is ignored outside IDLE.
REQ-018 CLEAR: mac_clr=1 for exactly one cycle, no rdreq.
REQ-019 STREAM runs global step s = 0 .. DEPTH+ROWS-2; row i is active at step s when 0 <= s-i < DEPTH; B is active when s < DEPTH.
REQ-020 A step fires in a cycle only when every active row's rdempty_a is 0 and, if B is active, rdempty_b is 0; otherwise no rdreq is asserted, s holds, and the cycle is a stall.
REQ-021 On a firing step, rdreq_a[i]=1 for exactly the active rows, rdreq_b=1 iff B is active, and s increments.
REQ-022 The cycle after a firing step, mac_en[i]=1 for each row that popped, mac_a[i]=q_a[i], and mac_b[i]=B element (s-i); mac_en is 0 in all other cycles.
REQ-023 Each row receives exactly DEPTH mac_en pulses per operation, in element order 0..DEPTH-1.
REQ-024 busy=1 from CLEAR through DONE inclusive; done=1 only in DONE.
REQ-025 No FIFO is read while its rdempty is 1; rdreq is never asserted outside STREAM.

Reset
REQ-026 rst_n low forces IDLE, s=0, B skew registers=0, stall_cnt=0, and all outputs 0, including mid-operation; partial results are abandoned.

Configuration
REQ-027 With FEEDER_STALL_CNT_EN defined, stall_cnt increments, saturating at 16'hFFFF, on each STREAM stall cycle and is cleared in CLEAR; without it, stall_cnt is tied to 0 and no counter logic exists.

Structure
REQ-028 Package minilab_pkg holds DATA_WIDTH, ROWS, DEPTH defaults and the FSM state enum type.
REQ-029 Sub-module b_skew_line implements the ROWS-stage B delay line that advances on firing steps.

Verification
REQ-030 All FIFOs pre-filled, A row i = i+1, B = 1..8, start at cycle 0 -> mac_clr at cycle 1, row i mac_en at cycles 3+i..10+i with mac_a=i+1 and mac_b=1..8, done at cycle 18, busy low at cycle 19.
REQ-031 B FIFO empty for the first 5 STREAM cycles -> no rdreq during those cycles, first mac_en[0] 5 cycles late, stall_cnt=5 with the macro defined and 0 without it.
REQ-032 rdempty_a[7] held high during steps 7..9 for 3 cycles -> all rdreq low for those 3 cycles, then sequence resumes in order with 8 pulses per row.
REQ-033 rst_n asserted at cycle 8 -> all outputs 0 asynchronously; new start after release -> mac_clr issued and the operation completes normally.
REQ-034 start pulsed again at cycle 6 -> ignored; exactly one done pulse.
REQ-035 A and B all 8'hFF -> mac_a and mac_b carry 8'hFF unaltered on every mac_en pulse.
